// File: rtl/seq_multiword_adder.sv
// Multi-word adder: streams WIDTH-bit beats through a carry-lookahead
// adder, chaining each beat's carry-out into the next beat's carry-in.

module cla_adder #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int NG = (WIDTH + SIZE - 1) / SIZE;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             gacc;
  logic             pacc;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat function of its group's incoming carry.
  always_comb begin
    c    = '0;
    gacc = 1'b0;
    pacc = 1'b1;
    c[0] = cin;
    for (int k = 0; k < NG; k++) begin
      gacc = 1'b0;
      pacc = 1'b1;
      for (int j = 0; j < SIZE; j++) begin
        if (k * SIZE + j < WIDTH) begin
          gacc = g[k*SIZE+j] | (p[k*SIZE+j] & gacc);
          pacc = pacc & p[k*SIZE+j];
          c[k*SIZE+j+1] = gacc | (pacc & c[k*SIZE]);
        end
      end
    end
  end

  assign s    = p ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

endmodule

module seq_multiword_adder #(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cout,
  output logic             out_last,
  input  logic             err_clr,
  output logic             err_seq,
  output logic             err_len
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state;
  state_t          state_n;
  logic            carry_q;
  logic [CW-1:0]   beat_cnt;
  logic            accept;
  logic            first_beat;
  logic            add_cin;
  logic            seq_hit;
  logic            len_hit;
  logic [WIDTH-1:0] sum;
  logic            sum_cout;

  cla_adder #(
    .WIDTH (WIDTH),
    .SIZE  (SIZE)
  ) u_add (
    .a    (in_a),
    .b    (in_b),
    .cin  (add_cin),
    .s    (sum),
    .cout (sum_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // An in_first while BUSY restarts; a missing in_first while IDLE still starts.
  always_comb begin
    state_n    = state;
    in_ready   = !out_valid || out_ready;
    accept     = in_valid && in_ready;
    first_beat = (state == IDLE) || in_first;
    add_cin    = first_beat ? in_cin : carry_q;
    seq_hit    = 1'b0;
    len_hit    = 1'b0;
    if (accept) begin
      state_n = in_last ? IDLE : BUSY;
      unique case (state)
        IDLE: seq_hit = !in_first;
        BUSY: seq_hit = in_first;
        default: seq_hit = 1'b0;
      endcase
      len_hit = !first_beat &&
                (beat_cnt == CW'(MAX_BEATS));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q  <= 1'b0;
      beat_cnt <= '0;
    end else if (accept) begin
      carry_q <= in_last ? 1'b0 : sum_cout;
      if (first_beat)
        beat_cnt <= CW'(1);
      else if (beat_cnt != CW'(MAX_BEATS))
        beat_cnt <= beat_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_s     <= '0;
      out_cout  <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_s     <= sum;
      out_cout  <= sum_cout;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_seq <= 1'b0;
      err_len <= 1'b0;
    end else begin
      if (seq_hit)      err_seq <= 1'b1;
      else if (err_clr) err_seq <= 1'b0;
      if (len_hit)      err_len <= 1'b1;
      else if (err_clr) err_len <= 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_multiword_adder.sv
// Scoreboard bench for seq_multiword_adder: directed packets at WIDTH=8,
// MAX_BEATS=2, with backpressure, framing, length and reset cases.

module tb_seq_multiword_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_first = 1'b0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_s;
  logic         out_cout;
  logic         out_last;
  logic         err_clr = 1'b0;
  logic         err_seq;
  logic         err_len;

  int n_checks = 0;
  int n_fail   = 0;
  int n_tx     = 0;
  int n_rx     = 0;
  logic [9:0] exp_q[$];

  seq_multiword_adder #(
    .WIDTH     (W),
    .SIZE      (4),
    .MAX_BEATS (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_cout  (out_cout),
    .out_last  (out_last),
    .err_clr   (err_clr),
    .err_seq   (err_seq),
    .err_len   (err_len)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_beat: got 0x%0h expected none",
                 {out_last, out_cout, out_s});
      end else begin
        check("beat", {22'd0, out_last, out_cout, out_s},
              {22'd0, exp_q.pop_front()});
        n_rx++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a beat and returns at posedge+1 right after it is accepted.
  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic cin,
                      logic first, logic last,
                      logic [W-1:0] es, logic ec);
    logic ok;
    int   n;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_first = first;
    in_last  = last;
    exp_q.push_back({last, ec, es});
    n_tx++;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      step();
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_s", {24'd0, out_s}, 32'd0);
    check("rst_errs", {30'd0, err_seq, err_len}, 32'd0);
    rst = 1'b0;
    step();
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    send(8'h7F, 8'h01, 1'b1, 1'b1, 1'b1, 8'h81, 1'b0);
    idle();
    step();

    send(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
    send(8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0);
    idle();
    step();
    check("two_beat_no_err", {30'd0, err_seq, err_len}, 32'd0);

    out_ready = 1'b0;
    send(8'hF0, 8'h20, 1'b0, 1'b1, 1'b0, 8'h10, 1'b1);
    in_valid = 1'b1;
    in_a     = 8'h0A;
    in_b     = 8'h05;
    in_cin   = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b1;
    exp_q.push_back({1'b1, 1'b0, 8'h10});
    n_tx++;
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold", {23'd0, out_valid, out_cout, out_s},
            {23'd0, 1'b1, 1'b1, 8'h10});
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    step();
    idle();
    step();

    send(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    send(8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0);
    idle();
    check("err_seq_restart", {31'd0, err_seq}, 32'd1);
    check("err_len_quiet", {31'd0, err_len}, 32'd0);
    clear_errs();
    check("err_seq_cleared", {31'd0, err_seq}, 32'd0);

    send(8'h10, 8'h20, 1'b1, 1'b0, 1'b1, 8'h31, 1'b0);
    idle();
    check("err_seq_nofirst", {31'd0, err_seq}, 32'd1);
    clear_errs();

    send(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1);
    send(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    check("len_at_max", {31'd0, err_len}, 32'd0);
    send(8'h01, 8'h02, 1'b0, 1'b0, 1'b1, 8'h04, 1'b0);
    idle();
    check("len_over", {31'd0, err_len}, 32'd1);
    check("len_no_seq", {31'd0, err_seq}, 32'd0);
    clear_errs();
    check("len_cleared", {31'd0, err_len}, 32'd0);

    out_ready = 1'b0;
    send(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    idle();
    rst = 1'b1;
    void'(exp_q.pop_back());
    n_tx--;
    #1;
    check("rst_async_valid", {31'd0, out_valid}, 32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    send(8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    idle();
    check("post_rst_no_seq", {31'd0, err_seq}, 32'd0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      step();
      n++;
    end
    step();
    check("drain_empty", exp_q.size(), 32'd0);
    check("beat_count", n_rx, n_tx);
    check("final_idle", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_multiword_adder.md
Name: seq_multiword_adder

Overview:
Sequential multi-word adder that streams wide operands as WIDTH-bit beats through the team's combinational carry-lookahead adder (WIDTH, SIZE) and carries cout of each beat into cin of the next. It sits directly around the adder. Upstream it drives a/b/cin from a valid/ready operand stream. Downstream it registers s/cout into a valid/ready result stream, which makes arbitrary-length additions at a fixed adder width possible.

Parameters:
WIDTH, 32, beat width in bits; adder width
SIZE, 4, lookahead group size passed to the carry-lookahead adder
MAX_BEATS, 16, maximum beats per packet before err_len is flagged (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand beat valid
in_ready  out  1  operand beat accepted when in_valid && in_ready
in_a  in  WIDTH  operand A beat, least-significant beat first
in_b  in  WIDTH  operand B beat
in_cin  in  1  carry-in; used only on a packet's first beat
in_first  in  1  first beat of packet
in_last  in  1  last beat of packet (first and last may both be 1)
out_valid  out  1  result beat valid
out_ready  in  1  result beat consumed when out_valid && out_ready
out_s  out  WIDTH  sum beat
out_cout  out  1  carry-out of this beat
out_last  out  1  copy of in_last for this beat
err_clr  in  1  clears sticky error flags
err_seq  out  1  sticky framing error
err_len  out  1  sticky packet-length error

Behaviour:
- Reset (asynchronous assert): state=IDLE, carry_q=0, beat_cnt=0, out_valid=0, out_s=0, out_cout=0, out_last=0, err_seq=0, err_len=0. Reset mid-packet drops the packet and any held result.
- Single output register. in_ready = !out_valid || out_ready, so full throughput holds with one cycle of latency.
- Accept cycle: adder inputs are a=in_a, b=in_b, cin=(first-beat ? in_cin : carry_q). The output register loads s, cout and in_last. out_valid=1 on the next edge.
- out_valid falls on an edge with out_ready=1 and no new accept. The output holds stable while out_valid && !out_ready.
- FSM IDLE (awaiting first beat):
  - accept with in_first=1: treated as first beat. Next state is IDLE if in_last, else BUSY.
  - accept with in_first=0: still treated as first beat (uses in_cin) and err_seq is set.
- FSM BUSY (mid-packet):
  - accept with in_first=0: continuation beat using carry_q.
  - accept with in_first=1: the old packet is abandoned and a new packet starts with in_cin. err_seq is set.
  - accept with in_last=1: next state IDLE.
- carry_q loads the adder cout on every accepted non-last beat. It clears to 0 on an accepted last beat.
- beat_cnt resets to 1 on a first beat and increments on each continuation beat, saturating at MAX_BEATS. err_len is set when a continuation beat is accepted while beat_cnt==MAX_BEATS, i.e. beat MAX_BEATS+1 arrives. That beat is still processed normally.
- Errors are sticky until err_clr=1, which clears them on the next edge. Set has priority over err_clr on the same edge.
- No accept occurs while in_valid=0. State, carry_q and beat_cnt hold.
- Arithmetic is modulo 2^WIDTH per beat. The packet sum equals the concatenated out_s beats plus the final out_cout as bit WIDTH*N.

Test Plan:
- WIDTH=8, out_ready=1. Single beat a=0x7F, b=0x01, cin=1, first=last=1 -> next cycle out_s=0x81, out_cout=0, out_last=1; state IDLE.
- WIDTH=8, 2-beat packet a={0x01,0xFF}, b={0x00,0x01} (LS beat first is 0xFF+0x01), cin=0 -> beat0 s=0x00, cout=1; beat1 s=0x02, cout=0, last=1; back-to-back accepts with in_ready held 1.
- Backpressure: out_ready=0 for 3 cycles after the first result -> out_s/out_cout held stable, in_ready=0. Release out_ready -> the next beat is accepted in the same cycle, no beat is lost or duplicated, and carry is preserved.
- Framing: in_first=1 mid-packet with cin=1, a=0x00, b=0x00 -> out_s=0x01 (stale carry ignored), err_seq=1. Pulse err_clr -> err_seq=0.
- Length: MAX_BEATS=2 with a 3-beat packet -> err_len=1 after beat 3 is accepted, and beat 3 is summed correctly.
- Reset mid-packet: assert rst after beat0 of a 2-beat packet with carry_q=1 -> out_valid=0 immediately. A new first beat 0x00+0x00, cin=0 -> s=0x00 (carry cleared).
